// File: rtl/pc_unit.sv
// pc_unit: prioritised next-PC selection with stall, branch/jump/jr and a
// circular return-address stack for call/return. Rev 1.0
`default_nettype none

module pc_unit #(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               PC_INC       = 4,
  parameter int               OFF_SHIFT    = 2,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [WIDTH-1:0] branch_offset_i,
  input  logic             jump_i,
  input  logic [WIDTH-1:0] jump_target_i,
  input  logic             jr_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic             call_i,
  input  logic             ret_i,
  output logic [WIDTH-1:0] cur_o,
  output logic [WIDTH-1:0] pc_plus_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             ras_overflow_o
);

  localparam int               PW       = $clog2(RAS_DEPTH);
  localparam int               CW       = PW + 1;
  localparam logic [WIDTH-1:0] INC      = WIDTH'(PC_INC);
  localparam logic [CW-1:0]    FULL_CNT = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] cur_q, cur_d;
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] pc_plus;
  logic             empty, full;
  logic             wr_en;
  logic [PW-1:0]    wr_idx;

  assign pc_plus = cur_q + INC;
  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);

  always_comb begin
    cur_d  = cur_q;
    top_d  = top_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    wr_en  = 1'b0;
    wr_idx = top_q + PW'(1);
    if (!stall_i) begin
      if (ret_i)               cur_d = empty ? rs_i : ras_q[top_q];
      else if (jr_i)           cur_d = rs_i;
      else if (jump_i)         cur_d = jump_target_i;
      else if (branch_taken_i) cur_d = pc_plus + (branch_offset_i << OFF_SHIFT);
      else                     cur_d = pc_plus;

      // ret+call on a non-empty stack replaces the top in place
      if (ret_i && call_i && !empty) begin
        wr_en  = 1'b1;
        wr_idx = top_q;
      end else if (call_i && (ret_i || jr_i || jump_i)) begin
        wr_en = 1'b1;
        top_d = top_q + PW'(1);
        if (full) ovf_d = 1'b1;
        else      cnt_d = cnt_q + CW'(1);
      end else if (ret_i && !empty) begin
        top_d = top_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cur_q <= RESET_VECTOR;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cur_q <= cur_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Entry contents need no reset; only count/pointer define validity
  always_ff @(posedge clk_i) begin
    if (wr_en) ras_q[wr_idx] <= pc_plus;
  end

  assign cur_o          = cur_q;
  assign pc_plus_o      = pc_plus;
  assign ras_empty_o    = empty;
  assign ras_full_o     = full;
  assign ras_overflow_o = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed plan steps plus random traffic against a stack-level model.
`default_nettype none

module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch_taken, jump, jr, call, ret;
  logic [31:0] branch_offset, jump_target, rs;
  logic [31:0] cur, pc_plus;
  logic        ras_empty, ras_full, ras_overflow;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_cur;
  logic [31:0] m_stk[$];
  logic        m_ovf;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk_i(clk), .reset_i(reset), .stall_i(stall),
    .branch_taken_i(branch_taken), .branch_offset_i(branch_offset),
    .jump_i(jump), .jump_target_i(jump_target), .jr_i(jr), .rs_i(rs),
    .call_i(call), .ret_i(ret),
    .cur_o(cur), .pc_plus_o(pc_plus), .ras_empty_o(ras_empty),
    .ras_full_o(ras_full), .ras_overflow_o(ras_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    stall = 0; branch_taken = 0; jump = 0; jr = 0; call = 0; ret = 0;
    branch_offset = '0; jump_target = '0; rs = '0;
  endtask

  task automatic model_reset();
    m_cur = 32'h0;
    m_stk.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_step();
    logic [31:0] pp, nxt;
    if (stall) return;
    pp = m_cur + 32'd4;
    if (ret)               nxt = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : rs;
    else if (jr)           nxt = rs;
    else if (jump)         nxt = jump_target;
    else if (branch_taken) nxt = pp + (branch_offset << 2);
    else                   nxt = pp;
    if (ret && call && m_stk.size() > 0) begin
      m_stk[m_stk.size()-1] = pp;
    end else if (call && (ret || jr || jump)) begin
      if (m_stk.size() == 4) begin
        void'(m_stk.pop_front());
        m_ovf = 1'b1;
      end
      m_stk.push_back(pp);
    end else if (ret && m_stk.size() > 0) begin
      void'(m_stk.pop_back());
    end
    m_cur = nxt;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cur"}, cur, m_cur);
    chk({tag, ".pc_plus"}, pc_plus, m_cur + 32'd4);
    chk({tag, ".empty"}, {31'b0, ras_empty}, {31'b0, m_stk.size() == 0});
    chk({tag, ".full"}, {31'b0, ras_full}, {31'b0, m_stk.size() == 4});
    chk({tag, ".ovf"}, {31'b0, ras_overflow}, {31'b0, m_ovf});
  endtask

  // Apply current inputs for one cycle, then compare against the model.
  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
    clr_in();
  endtask

  task automatic do_jump(input logic [31:0] t, input logic c);
    jump = 1; jump_target = t; call = c;
    step("jump");
  endtask

  initial begin
    clr_in();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.cur", cur, 32'h0);
    chk("reset.empty", {31'b0, ras_empty}, 32'h1);
    check_all("reset");
    reset = 1'b0;

    step("seq1"); chk("seq1.lit", cur, 32'h4);
    step("seq2"); chk("seq2.lit", cur, 32'h8);
    step("seq3"); chk("seq3.lit", cur, 32'hC);

    #2 reset = 1'b1;
    #1 chk("async_rst.cur", cur, 32'h0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    check_all("async_rst");

    do_jump(32'h100, 0);
    branch_taken = 1; branch_offset = 32'hFFFF_FFFE;
    step("branch_neg"); chk("branch_neg.lit", cur, 32'hFC);

    do_jump(32'hFFFF_FFFC, 0);
    step("wrap"); chk("wrap.lit", cur, 32'h0);

    do_jump(32'h40, 0);
    stall = 1; jr = 1; rs = 32'h800; jump = 1; jump_target = 32'h200; branch_taken = 1;
    step("stall"); chk("stall.lit", cur, 32'h40);
    jr = 1; rs = 32'h800; jump = 1; jump_target = 32'h200; branch_taken = 1;
    step("prio"); chk("prio.lit", cur, 32'h800);

    do_jump(32'h10, 0);
    do_jump(32'h300, 1); chk("call.lit", cur, 32'h300);
    ret = 1;
    step("ret"); chk("ret.lit", cur, 32'h14);
    chk("ret.empty", {31'b0, ras_empty}, 32'h1);
    ret = 1; rs = 32'h900;
    step("ret_empty"); chk("ret_empty.lit", cur, 32'h900);

    do_jump(32'h0, 0);
    for (int i = 1; i <= 5; i++) do_jump(32'h100 * i, 1);
    chk("ovf.full", {31'b0, ras_full}, 32'h1);
    chk("ovf.sticky", {31'b0, ras_overflow}, 32'h1);
    for (int i = 4; i >= 1; i--) begin
      ret = 1;
      step("ovf_ret");
      chk("ovf_ret.lit", cur, 32'h100 * i + 32'h4);
    end
    chk("ovf.drained", {31'b0, ras_empty}, 32'h1);

    reset = 1'b1;
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    do_jump(32'h20, 0);
    do_jump(32'h1000, 1);
    do_jump(32'h500, 0);
    ret = 1; jr = 1; call = 1; rs = 32'h700;
    step("retcall"); chk("retcall.lit", cur, 32'h24);
    ret = 1;
    step("retcall_pop"); chk("retcall_pop.lit", cur, 32'h504);
    chk("retcall.empty", {31'b0, ras_empty}, 32'h1);

    for (int n = 0; n < 400; n++) begin
      stall         = ($urandom_range(0, 99) < 15);
      ret           = ($urandom_range(0, 99) < 20);
      jr            = ($urandom_range(0, 99) < 15);
      jump          = ($urandom_range(0, 99) < 20);
      branch_taken  = ($urandom_range(0, 99) < 30);
      call          = ($urandom_range(0, 99) < 35);
      rs            = $urandom;
      jump_target   = $urandom;
      branch_offset = $urandom;
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
